// File: rtl/pwm_duty_decoder_if.sv
// pwm_duty_decoder_if: PWM link bundle; master drives Pulse_In, slave returns Duty_Out/Duty_Valid/Locked/Err
interface pwm_duty_decoder_if #(parameter int WIDTH = 6);
  logic             Pulse_In;
  logic [WIDTH-1:0] Duty_Out;
  logic             Duty_Valid;
  logic             Locked;
  logic             Err;
  modport master (output Pulse_In, input Duty_Out, Duty_Valid, Locked, Err);
  modport slave  (input Pulse_In, output Duty_Out, Duty_Valid, Locked, Err);
endinterface

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: recovers per-frame duty words from a PWM stream and tracks 2^WIDTH frame alignment
// Ports: sysclk/reset (sync, active-high); bus.Pulse_In async PWM in; bus.Duty_Out/Duty_Valid recovered
// duty + one-cycle strobe; bus.Locked frame alignment held; bus.Err one-cycle strobe on a misaligned rise.
module pwm_duty_decoder #(
  parameter int WIDTH       = 6,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FRAMES = 2
) (
  input logic              sysclk,
  input logic              reset,
  pwm_duty_decoder_if.slave bus
);
  localparam int LW = $clog2(LOCK_FRAMES + 1);
  localparam logic [WIDTH:0]  FULL     = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0]  ONE      = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [LW-1:0]   LOCK_MAX = LW'(LOCK_FRAMES);
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic [WIDTH-1:0]       phase;
  logic [WIDTH:0]         high_cnt;
  logic                   seen_rise;
  logic                   has_ref;
  logic [LW-1:0]          lock_cnt;
  logic                   s, rise, fall, boundary, zero_frame, stuck;
  logic [LW-1:0]          lock_nxt;
  always_comb begin
    s          = sync[SYNC_STAGES-1];
    rise       = s & ~prev;
    fall       = ~s & prev;
    boundary   = &phase;
    // a frame with no pulse at all still reports duty 0 once per period
    zero_frame = boundary & ~rise & ~seen_rise & ~s;
    // a stream stuck high reports full-scale once per period
    stuck      = boundary & s & (high_cnt == FULL);
    lock_nxt   = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;
  end
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync           <= '0;
      prev           <= 1'b0;
      phase          <= '0;
      high_cnt       <= '0;
      seen_rise      <= 1'b0;
      has_ref        <= 1'b0;
      lock_cnt       <= '0;
      bus.Duty_Out   <= '0;
      bus.Duty_Valid <= 1'b0;
      bus.Locked     <= 1'b0;
      bus.Err        <= 1'b0;
    end else begin
      sync           <= {sync[SYNC_STAGES-2:0], bus.Pulse_In};
      prev           <= s;
      phase          <= rise ? '0 : phase + 1'b1;
      high_cnt       <= rise ? ONE : (s && high_cnt != FULL) ? high_cnt + 1'b1 : high_cnt;
      seen_rise      <= boundary ? rise : (seen_rise | rise);
      bus.Duty_Valid <= fall | zero_frame | stuck;
      bus.Duty_Out   <= fall ? ((high_cnt == FULL) ? '1 : high_cnt[WIDTH-1:0]) :
                        zero_frame ? '0 : stuck ? '1 : bus.Duty_Out;
      // the first rise after reset only establishes the phase reference
      bus.Err        <= rise & has_ref & ~boundary;
      if (rise) begin
        has_ref <= 1'b1;
        if (has_ref) begin
          lock_cnt   <= boundary ? lock_nxt : '0;
          bus.Locked <= boundary & (lock_nxt == LOCK_MAX);
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: table-driven frame scenarios plus directed latency, stuck-high and reset sequences
module tb_pwm_duty_decoder;
  localparam int WIDTH = 6;
  typedef struct {
    int    pre_d;
    int    pre_n;
    int    d;
    int    n;
    int    p1;
    int    exp_valids;
    int    exp_last;
    int    exp_errs;
    int    exp_locked;
    string name;
  } row_t;
  logic sysclk = 1'b0;
  logic reset  = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic       meas   = 1'b0;
  logic [2:0] meas_d = '0;
  int   win_valids = 0;
  int   win_errs   = 0;
  int   win_last   = 0;
  int   err_total  = 0;
  int   vq[$];
  int   vdq[$];
  row_t rows[6];
  pwm_duty_decoder_if #(.WIDTH(WIDTH)) bus ();
  pwm_duty_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(2), .LOCK_FRAMES(2)) dut (
    .sysclk(sysclk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) begin
    cyc    <= cyc + 1;
    meas_d <= {meas_d[1:0], meas};
  end
  always @(negedge sysclk) begin
    if (bus.Duty_Valid) begin
      vq.push_back(cyc);
      vdq.push_back(int'(bus.Duty_Out));
    end
    if (bus.Err) err_total++;
    if (meas_d[2]) begin
      if (bus.Duty_Valid) begin
        win_valids++;
        win_last = int'(bus.Duty_Out);
      end
      if (bus.Err) win_errs++;
    end
  end
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int qcyc(input int idx);
    return (idx < vq.size()) ? vq[idx] : -1;
  endfunction
  function automatic int qval(input int idx);
    return (idx < vdq.size()) ? vdq[idx] : -1;
  endfunction
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask
  task automatic do_reset();
    tick();
    reset        = 1'b1;
    bus.Pulse_In = 1'b0;
    tick();
    reset = 1'b0;
  endtask
  task automatic drive_frame(input int d, input int p, input logic m, output int klow);
    klow = -1;
    for (int i = 0; i < p; i++) begin
      tick();
      bus.Pulse_In = (i < d);
      meas         = m;
      if (i == d) klow = cyc;
    end
  endtask
  initial begin
    int k, k3, base, e0, e_mid, v0, er0;
    int kl[4];
    bus.Pulse_In = 1'b0;
    rows[0] = '{20, 0, 20, 10, 64, 10, 20, 0, 1, "duty20"};
    rows[1] = '{20, 3,  0,  5, 64,  4,  0, 0, 1, "duty0"};
    rows[2] = '{20, 3, 63,  4, 64,  4, 63, 0, 1, "duty63"};
    rows[3] = '{32, 3, 32,  4, 50,  4, 32, 1, 1, "short_relock"};
    rows[4] = '{32, 3, 32,  3, 50,  3, 32, 1, 0, "short_unlock"};
    rows[5] = '{ 1, 0,  1,  3, 64,  3,  1, 0, 1, "duty1"};
    do_reset();
    check("rst_duty",   int'(bus.Duty_Out), 0);
    check("rst_valid",  int'(bus.Duty_Valid), 0);
    check("rst_locked", int'(bus.Locked), 0);
    check("rst_err",    int'(bus.Err), 0);
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int j = 0; j < rows[r].pre_n; j++) drive_frame(rows[r].pre_d, 64, 1'b0, k);
      v0  = win_valids;
      er0 = win_errs;
      for (int j = 0; j < rows[r].n; j++) drive_frame(rows[r].d, (j == 0) ? rows[r].p1 : 64, 1'b1, k);
      tick();
      bus.Pulse_In = 1'b0;
      meas         = 1'b0;
      repeat (3) tick();
      check({rows[r].name, "_valids"}, win_valids - v0, rows[r].exp_valids);
      check({rows[r].name, "_last"},   win_last, rows[r].exp_last);
      check({rows[r].name, "_errs"},   win_errs - er0, rows[r].exp_errs);
      check({rows[r].name, "_locked"}, int'(bus.Locked), rows[r].exp_locked);
    end
    do_reset();
    base = vq.size();
    e0   = err_total;
    for (int f = 0; f < 4; f++) drive_frame((f % 2 == 1) ? 62 : 1, 64, 1'b0, kl[f]);
    repeat (5) tick();
    check("alt_count", vq.size() - base, 4);
    for (int f = 0; f < 4; f++) begin
      check($sformatf("alt_val%0d", f), qval(base + f), (f % 2 == 1) ? 62 : 1);
      check($sformatf("alt_lat%0d", f), qcyc(base + f), kl[f] + 3);
    end
    check("alt_errs", err_total - e0, 0);
    do_reset();
    base = vq.size();
    e0   = err_total;
    drive_frame(63, 64, 1'b0, k);
    drive_frame(63, 64, 1'b0, k);
    tick();
    bus.Pulse_In = 1'b1;
    k3 = cyc;
    repeat (200) tick();
    bus.Pulse_In = 1'b0;
    repeat (8) tick();
    check("stuck_count", vq.size() - base, 6);
    for (int i = 0; i < 6; i++) check($sformatf("stuck_val%0d", i), qval(base + i), 63);
    check("stuck_t0",   qcyc(base + 2), k3 + 67);
    check("stuck_t1",   qcyc(base + 3), k3 + 131);
    check("stuck_t2",   qcyc(base + 4), k3 + 195);
    check("stuck_fall", qcyc(base + 5), k3 + 203);
    check("stuck_errs", err_total - e0, 0);
    check("stuck_locked", int'(bus.Locked), 1);
    do_reset();
    for (int j = 0; j < 3; j++) drive_frame(32, 64, 1'b0, k);
    base  = vq.size();
    e0    = err_total;
    e_mid = -1;
    k     = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      bus.Pulse_In = (i < 32);
      reset        = (i == 10);
      if (i == 0) k = cyc;
      if (i == 11) begin
        check("mid_rst_duty",   int'(bus.Duty_Out), 0);
        check("mid_rst_valid",  int'(bus.Duty_Valid), 0);
        check("mid_rst_locked", int'(bus.Locked), 0);
        check("mid_rst_err",    int'(bus.Err), 0);
        e0 = err_total;
      end
      if (i == 40) e_mid = err_total;
    end
    drive_frame(32, 64, 1'b0, kl[0]);
    repeat (5) tick();
    check("mid_count",      vq.size() - base, 2);
    check("mid_partial",    qval(base), 21);
    check("mid_partial_t",  qcyc(base), k + 35);
    check("mid_full",       qval(base + 1), 32);
    check("mid_first_err",  e_mid - e0, 0);
    check("mid_second_err", err_total - e0, 1);
    check("mid_locked",     int'(bus.Locked), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
